// File: rtl/mw_writeback_stage.sv
// M/W pipeline register with writeback resolution: the W-stage GRF write address,
// write data and write enable, which also serve as the W-stage forwarding source.
module mw_writeback_stage #(
  parameter logic [31:0] PC_OFFSET = 32'd8,
  parameter int          LINK_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] instr_M,
  input  logic [31:0] pc_M,
  input  logic [31:0] alu_M,
  input  logic [31:0] dm_rd_M,
  input  logic        reg_write_M,
  input  logic [1:0]  grf_a3_sel_M,
  input  logic [1:0]  grf_wd_sel_M,
  input  logic [2:0]  load_type_M,
  output logic [31:0] instr_W,
  output logic [31:0] pc_W,
  output logic        grf_we_W,
  output logic [4:0]  grf_a3_W,
  output logic [31:0] grf_wd_W
);

  localparam logic [4:0] LINK_A3 = 5'(LINK_REG);

  localparam logic [1:0] A3_RT   = 2'd0;
  localparam logic [1:0] A3_RD   = 2'd1;
  localparam logic [1:0] A3_LINK = 2'd2;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DM   = 2'd1;
  localparam logic [1:0] WD_LINK = 2'd2;

  localparam logic [2:0] LD_LBU  = 3'd1;
  localparam logic [2:0] LD_LB   = 3'd2;
  localparam logic [2:0] LD_LHU  = 3'd3;
  localparam logic [2:0] LD_LH   = 3'd4;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] dm_rd_q, dm_rd_d;
  logic        reg_write_q, reg_write_d;
  logic [1:0]  a3_sel_q, a3_sel_d;
  logic [1:0]  wd_sel_q, wd_sel_d;
  logic [2:0]  load_type_q, load_type_d;

  // Picks the addressed byte/halfword of the raw DM word and extends it.
  // alu[0] is ignored for halfwords; misalignment is trapped elsewhere.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  ltype);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (ltype)
      LD_LBU:  load_extend = {24'd0, b};
      LD_LB:   load_extend = {{24{b[7]}}, b};
      LD_LHU:  load_extend = {16'd0, h};
      LD_LH:   load_extend = {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    alu_d       = alu_q;
    dm_rd_d     = dm_rd_q;
    reg_write_d = reg_write_q;
    a3_sel_d    = a3_sel_q;
    wd_sel_d    = wd_sel_q;
    load_type_d = load_type_q;
    if (flush) begin
      instr_d     = '0;
      pc_d        = '0;
      alu_d       = '0;
      dm_rd_d     = '0;
      reg_write_d = 1'b0;
      a3_sel_d    = '0;
      wd_sel_d    = '0;
      load_type_d = '0;
    end else if (en) begin
      instr_d     = instr_M;
      pc_d        = pc_M;
      alu_d       = alu_M;
      dm_rd_d     = dm_rd_M;
      reg_write_d = reg_write_M;
      a3_sel_d    = grf_a3_sel_M;
      wd_sel_d    = grf_wd_sel_M;
      load_type_d = load_type_M;
    end
  end

  // M -> W boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q     <= '0;
      pc_q        <= '0;
      alu_q       <= '0;
      dm_rd_q     <= '0;
      reg_write_q <= 1'b0;
      a3_sel_q    <= '0;
      wd_sel_q    <= '0;
      load_type_q <= '0;
    end else begin
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      dm_rd_q     <= dm_rd_d;
      reg_write_q <= reg_write_d;
      a3_sel_q    <= a3_sel_d;
      wd_sel_q    <= wd_sel_d;
      load_type_q <= load_type_d;
    end
  end

  always_comb begin
    case (a3_sel_q)
      A3_RT:   grf_a3_W = instr_q[20:16];
      A3_RD:   grf_a3_W = instr_q[15:11];
      A3_LINK: grf_a3_W = LINK_A3;
      default: grf_a3_W = 5'd0;
    endcase
  end

  // Suppressing $0 writes keeps the hazard unit from ever forwarding into $0.
  assign grf_we_W = reg_write_q & (grf_a3_W != 5'd0);

  always_comb begin
    case (wd_sel_q)
      WD_ALU:  grf_wd_W = alu_q;
      WD_DM:   grf_wd_W = load_extend(dm_rd_q, alu_q[1:0], load_type_q);
      WD_LINK: grf_wd_W = pc_q + PC_OFFSET;
      default: grf_wd_W = 32'd0;
    endcase
  end

  assign instr_W = instr_q;
  assign pc_W    = pc_q;

endmodule

// File: tb/tb_mw_writeback_stage.sv
// Directed and randomized bench for mw_writeback_stage against a behavioural
// model of the M/W capture and writeback rules.
module tb_mw_writeback_stage;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic [31:0] instr_M;
  logic [31:0] pc_M;
  logic [31:0] alu_M;
  logic [31:0] dm_rd_M;
  logic        reg_write_M;
  logic [1:0]  grf_a3_sel_M;
  logic [1:0]  grf_wd_sel_M;
  logic [2:0]  load_type_M;
  logic [31:0] instr_W;
  logic [31:0] pc_W;
  logic        grf_we_W;
  logic [4:0]  grf_a3_W;
  logic [31:0] grf_wd_W;

  int compared   = 0;
  int mismatched = 0;

  // Model state: the instruction currently sitting in W.
  logic [31:0] m_instr, m_pc, m_alu, m_dm;
  logic        m_rw;
  logic [1:0]  m_a3s, m_wds;
  logic [2:0]  m_lt;

  mw_writeback_stage #(.PC_OFFSET(32'd8), .LINK_REG(31)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .flush        (flush),
    .instr_M      (instr_M),
    .pc_M         (pc_M),
    .alu_M        (alu_M),
    .dm_rd_M      (dm_rd_M),
    .reg_write_M  (reg_write_M),
    .grf_a3_sel_M (grf_a3_sel_M),
    .grf_wd_sel_M (grf_wd_sel_M),
    .load_type_M  (load_type_M),
    .instr_W      (instr_W),
    .pc_W         (pc_W),
    .grf_we_W     (grf_we_W),
    .grf_a3_W     (grf_a3_W),
    .grf_wd_W     (grf_wd_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_a3();
    case (m_a3s)
      2'd0:    return (m_instr >> 16) & 32'd31;
      2'd1:    return (m_instr >> 11) & 32'd31;
      2'd2:    return 32'd31;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_we();
    return (m_rw && exp_a3() != 32'd0) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_load();
    logic [31:0] byt, half;
    byt  = (m_dm >> (8 * (m_alu % 4))) & 32'hFF;
    half = ((m_alu & 32'd2) != 0) ? (m_dm >> 16) : (m_dm & 32'hFFFF);
    case (m_lt)
      3'd1:    return byt;
      3'd2:    return (byt >= 32'd128) ? (byt | 32'hFFFFFF00) : byt;
      3'd3:    return half;
      3'd4:    return (half >= 32'h8000) ? (half | 32'hFFFF0000) : half;
      default: return m_dm;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd();
    case (m_wds)
      2'd0:    return m_alu;
      2'd1:    return exp_load();
      2'd2:    return m_pc + 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_instr"}, instr_W, m_instr);
    chk({tag, "_pc"}, pc_W, m_pc);
    chk({tag, "_we"}, {31'd0, grf_we_W}, exp_we());
    chk({tag, "_a3"}, {27'd0, grf_a3_W}, exp_a3());
    chk({tag, "_wd"}, grf_wd_W, exp_wd());
  endtask

  // Advance one edge, updating the model from the inputs present at that edge.
  task automatic tick();
    if (reset || flush) begin
      m_instr = 0; m_pc = 0; m_alu = 0; m_dm = 0;
      m_rw = 0; m_a3s = 0; m_wds = 0; m_lt = 0;
    end else if (en) begin
      m_instr = instr_M; m_pc = pc_M; m_alu = alu_M; m_dm = dm_rd_M;
      m_rw = reg_write_M; m_a3s = grf_a3_sel_M; m_wds = grf_wd_sel_M; m_lt = load_type_M;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] dm, input logic rw, input logic [1:0] a3s,
                       input logic [1:0] wds, input logic [2:0] lt);
    instr_M = ins; pc_M = pc; alu_M = alu; dm_rd_M = dm;
    reg_write_M = rw; grf_a3_sel_M = a3s; grf_wd_sel_M = wds; load_type_M = lt;
  endtask

  task automatic drive_random();
    drive($urandom, $urandom, $urandom, $urandom, 1'($urandom),
          2'($urandom), 2'($urandom), 3'($urandom));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_instr"}, instr_W, 32'd0);
    chk({tag, "_pc"}, pc_W, 32'd0);
    chk({tag, "_we"}, {31'd0, grf_we_W}, 32'd0);
    chk({tag, "_a3"}, {27'd0, grf_a3_W}, 32'd0);
    chk({tag, "_wd"}, grf_wd_W, 32'd0);
  endtask

  task automatic load_case(input string tag, input logic [2:0] lt,
                           input logic [31:0] alu, input logic [31:0] exp);
    drive(32'h8C050000, 32'h00001000, alu, 32'h80FF7F01, 1'b1, 2'd0, 2'd1, lt);
    tick();
    chk({tag, "_wd"}, grf_wd_W, exp);
    chk({tag, "_a3"}, {27'd0, grf_a3_W}, 32'd5);
    check_model(tag);
  endtask

  initial begin
    m_instr = 0; m_pc = 0; m_alu = 0; m_dm = 0;
    m_rw = 0; m_a3s = 0; m_wds = 0; m_lt = 0;
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    drive(32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h55AA55AA, 1'b1, 2'd1, 2'd2, 3'd2);

    // Reset held two cycles with live inputs.
    tick(); check_zero("reset1");
    tick(); check_zero("reset2");
    reset = 1'b0;

    // R-type add $8,$9,$10
    drive(32'h012A4020, 32'h00003000, 32'h00000015, 32'h0, 1'b1, 2'd1, 2'd0, 3'd0);
    tick();
    chk("rtype_a3", {27'd0, grf_a3_W}, 32'd8);
    chk("rtype_wd", grf_wd_W, 32'h15);
    chk("rtype_we", {31'd0, grf_we_W}, 32'd1);
    check_model("rtype");

    // jal link, then PC wrap
    drive(32'h0C000C04, 32'h00003010, 32'h0, 32'h0, 1'b1, 2'd2, 2'd2, 3'd0);
    tick();
    chk("jal_a3", {27'd0, grf_a3_W}, 32'd31);
    chk("jal_wd", grf_wd_W, 32'h00003018);
    chk("jal_we", {31'd0, grf_we_W}, 32'd1);
    pc_M = 32'hFFFFFFFC;
    tick();
    chk("jalwrap_wd", grf_wd_W, 32'h00000004);
    check_model("jalwrap");

    load_case("lb",  3'd2, 32'h2, 32'hFFFFFFFF);
    load_case("lbu", 3'd1, 32'h3, 32'h00000080);
    load_case("lh",  3'd4, 32'h2, 32'hFFFF80FF);
    load_case("lhu", 3'd0 + 3'd3, 32'h0, 32'h00007F01);
    load_case("lw",  3'd0, 32'h0, 32'h80FF7F01);
    load_case("lw7", 3'd7, 32'h1, 32'h80FF7F01);
    load_case("lh_odd", 3'd4, 32'h3, 32'hFFFF80FF);

    // $0 suppression
    drive(32'h00003820, 32'h0, 32'h77, 32'h0, 1'b1, 2'd0, 2'd0, 3'd0);
    tick();
    chk("zero_rt_we", {31'd0, grf_we_W}, 32'd0);
    drive(32'h00003820, 32'h0, 32'h77, 32'h0, 1'b1, 2'd3, 2'd0, 3'd0);
    tick();
    chk("nodest_a3", {27'd0, grf_a3_W}, 32'd0);
    chk("nodest_we", {31'd0, grf_we_W}, 32'd0);

    // Hold, then flush with en=0, then reset+flush together
    drive(32'h012A4020, 32'h00003000, 32'h00000015, 32'h0, 1'b1, 2'd1, 2'd0, 3'd0);
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      tick();
      chk("hold_instr", instr_W, 32'h012A4020);
      chk("hold_a3", {27'd0, grf_a3_W}, 32'd8);
      chk("hold_wd", grf_wd_W, 32'h15);
      chk("hold_we", {31'd0, grf_we_W}, 32'd1);
    end
    flush = 1'b1;
    tick(); check_zero("flush_noen");
    en = 1'b1; flush = 1'b0;
    drive(32'h012A4020, 32'h00003000, 32'h00000015, 32'h0, 1'b1, 2'd1, 2'd0, 3'd0);
    tick();
    reset = 1'b1; flush = 1'b1;
    drive_random();
    tick(); check_zero("reset_flush");
    reset = 1'b0; flush = 1'b0;

    // Randomized traffic with occasional stalls, bubbles and resets
    for (int i = 0; i < 400; i++) begin
      drive_random();
      en    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 29) == 0);
      tick();
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mw_writeback_stage.md
Name: mw_writeback_stage

Overview:
- M/W pipeline register plus writeback resolution for the P5 pipelined MIPS CPU.
- Captures M-stage results, PC, instruction, write-enable and the two GRF select codes from the GRF select control logic at each clock edge.
- In W it produces the final GRF write address, write data and write enable.
- The same W-stage values drive the GRF write port and the W-stage forwarding sources used by the hazard unit.

Parameters:
- PC_OFFSET, 8, value added to the captured PC for link writes (jal/jalr).
- LINK_REG, 31, GRF index used when the A3 select is 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous active-high reset.
- en  input  1  M/W register load enable; 0 holds the current contents.
- flush  input  1  loads a bubble into W on the next edge.
- instr_M  input  32  M-stage instruction word.
- pc_M  input  32  M-stage instruction address.
- alu_M  input  32  M-stage ALU result; also the DM byte address.
- dm_rd_M  input  32  raw word read from data memory.
- reg_write_M  input  1  M-stage instruction writes the GRF.
- grf_a3_sel_M  input  2  0=rt, 1=rd, 2=LINK_REG, 3=no destination.
- grf_wd_sel_M  input  2  0=ALU, 1=DM load, 2=PC+PC_OFFSET, 3=zero.
- load_type_M  input  3  0=lw, 1=lbu, 2=lb, 3=lhu, 4=lh, 5-7 treated as lw.
- instr_W  output  32  registered instruction.
- pc_W  output  32  registered PC.
- grf_we_W  output  1  GRF write enable.
- grf_a3_W  output  5  GRF write address.
- grf_wd_W  output  32  GRF write data.

Behaviour:
- One register set for every M input: instr, pc, alu, dm_rd, reg_write, both selects, load_type.
- Update priority at each posedge clk: reset > flush > en.
  - reset=1: all registers cleared to 0.
  - flush=1: all registers cleared to 0 (bubble), regardless of en.
  - en=1: load the M inputs.
  - en=0: hold the current contents.
- Outputs are combinational from the registers only; no M input reaches any output in the same cycle. Latency M->W is exactly 1 cycle.
- After reset or flush:
  - instr_W=0, pc_W=0, grf_we_W=0, grf_a3_W=0, grf_wd_W=0.
  - Reason: the cleared reg_write gives we=0, and sel=0 of a zero instr gives rt=0.
- grf_a3_W selection:
  - sel 0: instr[20:16].
  - sel 1: instr[15:11].
  - sel 2: LINK_REG[4:0].
  - sel 3: 0.
- grf_we_W = reg_write & (grf_a3_W != 0). Writes to $0 are never asserted. This is required so forwarding never sources $0.
- grf_wd_W selection:
  - sel 0: alu.
  - sel 1: extended load data.
  - sel 2: pc + PC_OFFSET, modulo 2^32 (0xFFFFFFFC+8 wraps to 0x00000004).
  - sel 3: 0.
- Load extension, using registered alu[1:0] as the byte offset:
  - byte b = dm_rd[8*off+7 : 8*off].
  - lbu zero-extends b; lb sign-extends b.
  - halfword h = dm_rd[31:16] if alu[1]=1, else dm_rd[15:0]; alu[0] is ignored (no misalignment trap in this block).
  - lhu zero-extends h; lh sign-extends h.
  - lw and types 5-7 pass dm_rd unchanged.
- grf_wd_W is valid whenever grf_we_W=0, but is don't-care for the GRF in that case.
- Simultaneous reset and flush: reset behaviour.
- en=0 with flush=1: bubble.

Test Plan:
- Reset: hold reset 2 cycles with arbitrary non-zero M inputs -> all outputs 0 on the cycle after each edge.
- R-type: instr_M=0x012A4020 (add $8,$9,$10), a3_sel=1, wd_sel=0, alu_M=0x00000015, reg_write=1 -> next cycle a3_W=8, wd_W=0x15, we_W=1.
- jal link: pc_M=0x00003010, a3_sel=2, wd_sel=2, reg_write=1 -> a3_W=31, wd_W=0x00003018, we_W=1. Repeat with pc_M=0xFFFFFFFC -> wd_W=0x00000004.
- Loads with dm_rd_M=0x80FF7F01, wd_sel=1, a3_sel=0, rt=5:
  - lb, alu_M=0x2 -> wd=0xFFFFFFFF.
  - lbu, alu_M=0x3 -> wd=0x00000080.
  - lh, alu_M=0x2 -> wd=0xFFFF80FF.
  - lhu, alu_M=0x0 -> wd=0x00007F01.
  - lw -> wd=0x80FF7F01.
- $0 suppression: reg_write=1, a3_sel=0, rt=0 -> we_W=0. Then a3_sel=3 with rd=7 -> a3_W=0, we_W=0.
- Hold and flush: load a valid add, then en=0 for 3 cycles with changing inputs -> W outputs unchanged. Then flush=1 with en=0 -> bubble (all outputs 0) next cycle. Then reset=1 and flush=1 together -> all outputs 0.
